mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//   Multicycle control unit for the next-generation MIPS core: replaces the single-cycle decoder with an FSM that
//   sequences fetch/decode/execute/memory/writeback over a shared, variable-latency memory port (req/ack).
//   Drives datapath mux selects and register enables, counts retired instructions, and flags a memory timeout.
//   Sits between IR/ALU flags and the multicycle datapath (PC, IR, A/B, ALUOut, MDR registers).
// PARAMETERS
//   TIMEOUT   16  max cycles Mem_Req may stay high without Mem_Ack before fault (>=2)
//   TO_W      5   width of timeout counter (must hold TIMEOUT)
//   CNT_W     32  width of retired-instruction counter
// PORTS
//   Clock        in   1      rising-edge clock
//   Reset        in   1      synchronous, active-high
//   Opcode       in   6      IR[31:26], valid from DECODE onward
//   Funct        in   6      IR[5:0]
//   Zero         in   1      ALU zero flag (combinational, same cycle)
//   Mem_Ack      in   1      memory done; 1-cycle pulse; read data valid same cycle
//   Eof          in   1      halt request; sampled only in FETCH
//   Mem_Req      out  1      memory access request, held until Mem_Ack
//   Mem_Write    out  1      1=write, valid while Mem_Req
//   I_or_D       out  1      0=PC address, 1=ALUOut address
//   IR_Write     out  1      load IR (with Mem_Ack in FETCH)
//   MDR_Write    out  1      load MDR (with Mem_Ack in MEM_RD)
//   PC_Write     out  1      unconditional PC load
//   PC_Src       out  2      0=ALU(PC+4) 1=ALUOut(branch tgt) 2=jump tgt 3=A (jr)
//   ALU_Src_A    out  1      0=PC 1=A
//   ALU_Src_B    out  2      0=B 1=const 4 2=signext 3=signext<<2
//   ALU_Op       out  3      to alu_control: 0=add 1=sub 2=R-type(funct) 3=and 4=or 5=slt
//   Reg_Write    out  1      register file write enable
//   Reg_Dst      out  2      0=rt 1=rd 2=$31
//   Mem_to_Reg   out  2      0=ALUOut 1=MDR 2=PC (link)
//   State        out  4      current state encoding (debug)
//   Instr_Count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
//   Halted       out  1      FSM in HALT
//   Fault        out  1      sticky: memory timeout or illegal opcode
// BEHAVIOUR
//   Reset (sync): state=FETCH, Instr_Count=0, timeout cnt=0, Fault=0; all other outputs are state-decoded (0 in FETCH
//     except Mem_Req=1, ALU_Src_B=1). Reset mid-access drops Mem_Req next cycle; pending Mem_Ack is ignored.
//   States: FETCH(0) DECODE(1) EXEC_R(2) EXEC_I(3) MEM_ADDR(4) MEM_RD(5) MEM_WR(6) WB_R(7) WB_I(8) WB_MEM(9)
//     BRANCH(10) JUMP(11) JR(12) HALT(13) FAULT(14).
//   FETCH: Eof=1 -> HALT (no request issued that cycle). Else Mem_Req=1,I_or_D=0; on Mem_Ack: IR_Write=1,
//     PC_Write=1,PC_Src=0 (PC+4) -> DECODE; else stay.
//   DECODE (1 cyc): ALU_Src_A=0,ALU_Src_B=3,ALU_Op=0 (branch tgt into ALUOut). Dispatch on Opcode:
//     0x00: Funct=0x08 -> JR, else EXEC_R; 0x23/0x2B -> MEM_ADDR; 0x08/0x0C/0x0D/0x0A -> EXEC_I;
//     0x04/0x05 -> BRANCH; 0x02/0x03 -> JUMP; other -> FAULT.
//   EXEC_R: Src_A=1,Src_B=0,ALU_Op=2 -> WB_R (Reg_Write,Reg_Dst=1,Mem_to_Reg=0) -> FETCH.
//   EXEC_I: Src_A=1,Src_B=2, ALU_Op add/and/or/slt for addi/andi/ori/slti -> WB_I (Reg_Dst=0) -> FETCH.
//   MEM_ADDR: Src_A=1,Src_B=2,ALU_Op=0 -> MEM_RD (lw) or MEM_WR (sw).
//   MEM_RD/MEM_WR: Mem_Req=1,I_or_D=1, Mem_Write=1 for MEM_WR; wait for Mem_Ack; MEM_RD then WB_MEM
//     (Reg_Dst=0,Mem_to_Reg=1); MEM_WR then FETCH.
//   BRANCH: Src_A=1,Src_B=0,ALU_Op=1; PC_Write=PC_Src(1) when (beq&Zero)|(bne&!Zero) -> FETCH.
//   JUMP: PC_Write=1,PC_Src=2; jal also Reg_Write=1,Reg_Dst=2,Mem_to_Reg=2 (PC already +4) -> FETCH.
//   JR: PC_Write=1,PC_Src=3, Reg_Write=0 (jr never writes rd) -> FETCH.
//   Latency: R/I/branch/jump 3-4 cycles + fetch wait; lw 5 + 2 waits; sw 4 + 2 waits; zero-wait ack = 1 cycle.
//   Timeout: counter clears on entry to any memory state and on Mem_Ack; increments each cycle Mem_Req=1 w/o ack;
//     reaching TIMEOUT -> FAULT. Ack on the TIMEOUT-th cycle wins (access completes).
//   Instr_Count increments on the final cycle of each instruction (transition back to FETCH); not in FAULT/HALT.
//   HALT and FAULT are absorbing until Reset; all enables 0, Mem_Req=0. Fault=1 only via FAULT state.
//   Mem_Ack outside FETCH/MEM_RD/MEM_WR is ignored.
// TESTING
//   1 Reset, Mem_Ack always 1, add (op 0,funct 0x20) -> FETCH,DECODE,EXEC_R,WB_R; Reg_Write 1 cyc; Instr_Count=1.
//   2 lw with Mem_Ack delayed 3 cyc in MEM_RD -> Mem_Req held 3 cyc, MDR_Write on ack cycle, WB_MEM Mem_to_Reg=1.
//   3 beq Zero=1 -> PC_Write=1,PC_Src=1 in BRANCH; bne Zero=1 -> PC_Write=0; both retire in 3 cycles post-fetch.
//   4 jal -> PC_Src=2, Reg_Dst=2, Mem_to_Reg=2, Reg_Write=1; jr (funct 0x08) -> PC_Src=3, Reg_Write=0.
//   5 Mem_Ack never arrives in FETCH, TIMEOUT=16 -> FAULT after 16 cycles, Fault=1 sticky; Reset clears.
//   6 Opcode 0x3F -> FAULT; Eof=1 in FETCH -> HALT, Mem_Req=0; Reset asserted mid-MEM_WR -> FETCH next cycle.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit.
// A state machine steps each instruction through fetch, decode, execute,
// memory and writeback over one shared memory port that uses a req/ack
// handshake. It drives the datapath mux selects and register enables,
// counts retired instructions, and faults on a memory timeout or an
// illegal opcode.
module mips_multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5,
  parameter int CNT_W   = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             Mem_Ack,
  input  logic             Eof,
  output logic             Mem_Req,
  output logic             Mem_Write,
  output logic             I_or_D,
  output logic             IR_Write,
  output logic             MDR_Write,
  output logic             PC_Write,
  output logic [1:0]       PC_Src,
  output logic             ALU_Src_A,
  output logic [1:0]       ALU_Src_B,
  output logic [2:0]       ALU_Op,
  output logic             Reg_Write,
  output logic [1:0]       Reg_Dst,
  output logic [1:0]       Mem_to_Reg,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Instr_Count,
  output logic             Halted,
  output logic             Fault
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_MEM_ADDR = 4'd4;
  localparam logic [3:0] S_MEM_RD   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_WB_R     = 4'd7;
  localparam logic [3:0] S_WB_I     = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_JR       = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;
  localparam logic [3:0] S_FAULT    = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [3:0]       state;
  logic [3:0]       state_next;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] instr_cnt;
  logic             to_expire;
  logic             retire;

  // The timeout fires on the TIMEOUT-th waiting cycle unless the ack arrives in that same cycle.
  always_comb begin
    to_expire = Mem_Req && !Mem_Ack && (to_cnt == TO_W'(TIMEOUT - 1));
    retire    = (state_next == S_FETCH) && (state != S_FETCH);
  end

  // Next-state logic. HALT and FAULT are absorbing; only Reset leaves them.
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (Eof)            state_next = S_HALT;
        else if (Mem_Ack)   state_next = S_DECODE;
        else if (to_expire) state_next = S_FAULT;
      end
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:                         state_next = (Funct == FN_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:                     state_next = S_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_EXEC_I;
          OP_BEQ, OP_BNE:                   state_next = S_BRANCH;
          OP_J, OP_JAL:                     state_next = S_JUMP;
          default:                          state_next = S_FAULT;
        endcase
      end
      S_EXEC_R:   state_next = S_WB_R;
      S_EXEC_I:   state_next = S_WB_I;
      S_MEM_ADDR: state_next = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (Mem_Ack)        state_next = S_WB_MEM;
        else if (to_expire) state_next = S_FAULT;
      end
      S_MEM_WR: begin
        if (Mem_Ack)        state_next = S_FETCH;
        else if (to_expire) state_next = S_FAULT;
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JR: state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
  end

  // Datapath controls are decoded from the current state (plus the handshake and flags).
  always_comb begin
    Mem_Req    = 1'b0;
    Mem_Write  = 1'b0;
    I_or_D     = 1'b0;
    IR_Write   = 1'b0;
    MDR_Write  = 1'b0;
    PC_Write   = 1'b0;
    PC_Src     = 2'd0;
    ALU_Src_A  = 1'b0;
    ALU_Src_B  = 2'd0;
    ALU_Op     = 3'd0;
    Reg_Write  = 1'b0;
    Reg_Dst    = 2'd0;
    Mem_to_Reg = 2'd0;
    case (state)
      S_FETCH: begin
        ALU_Src_B = 2'd1;
        Mem_Req   = !Eof;
        IR_Write  = !Eof && Mem_Ack;
        PC_Write  = !Eof && Mem_Ack;
      end
      S_DECODE: begin
        ALU_Src_B = 2'd3;
      end
      S_EXEC_R: begin
        ALU_Src_A = 1'b1;
        ALU_Op    = 3'd2;
      end
      S_EXEC_I: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'd2;
        case (Opcode)
          OP_ANDI: ALU_Op = 3'd3;
          OP_ORI:  ALU_Op = 3'd4;
          OP_SLTI: ALU_Op = 3'd5;
          default: ALU_Op = 3'd0;
        endcase
      end
      S_MEM_ADDR: begin
        ALU_Src_A = 1'b1;
        ALU_Src_B = 2'd2;
      end
      S_MEM_RD: begin
        Mem_Req   = 1'b1;
        I_or_D    = 1'b1;
        MDR_Write = Mem_Ack;
      end
      S_MEM_WR: begin
        Mem_Req   = 1'b1;
        I_or_D    = 1'b1;
        Mem_Write = 1'b1;
      end
      S_WB_R: begin
        Reg_Write = 1'b1;
        Reg_Dst   = 2'd1;
      end
      S_WB_I: begin
        Reg_Write = 1'b1;
      end
      S_WB_MEM: begin
        Reg_Write  = 1'b1;
        Mem_to_Reg = 2'd1;
      end
      S_BRANCH: begin
        ALU_Src_A = 1'b1;
        ALU_Op    = 3'd1;
        PC_Src    = 2'd1;
        PC_Write  = ((Opcode == OP_BEQ) && Zero) || ((Opcode == OP_BNE) && !Zero);
      end
      S_JUMP: begin
        PC_Write = 1'b1;
        PC_Src   = 2'd2;
        if (Opcode == OP_JAL) begin
          Reg_Write  = 1'b1;
          Reg_Dst    = 2'd2;
          Mem_to_Reg = 2'd2;
        end
      end
      S_JR: begin
        PC_Write = 1'b1;
        PC_Src   = 2'd3;
      end
      default: begin
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // The timeout counter only runs while a request keeps waiting in the same state.
  always_ff @(posedge Clock) begin
    if (Reset)                                           to_cnt <= '0;
    else if (Mem_Req && !Mem_Ack && state_next == state) to_cnt <= to_cnt + TO_W'(1);
    else                                                 to_cnt <= '0;
  end

  // An instruction retires when the FSM returns to FETCH from any other state.
  always_ff @(posedge Clock) begin
    if (Reset)       instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  assign State       = state;
  assign Instr_Count = instr_cnt;
  assign Halted      = (state == S_HALT);
  assign Fault       = (state == S_FAULT);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mips_multicycle_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [5:0]  Opcode;
  logic [5:0]  Funct;
  logic        Zero;
  logic        Mem_Ack;
  logic        Eof;
  logic        Mem_Req;
  logic        Mem_Write;
  logic        I_or_D;
  logic        IR_Write;
  logic        MDR_Write;
  logic        PC_Write;
  logic [1:0]  PC_Src;
  logic        ALU_Src_A;
  logic [1:0]  ALU_Src_B;
  logic [2:0]  ALU_Op;
  logic        Reg_Write;
  logic [1:0]  Reg_Dst;
  logic [1:0]  Mem_to_Reg;
  logic [3:0]  State;
  logic [31:0] Instr_Count;
  logic        Halted;
  logic        Fault;

  int pass_count = 0;
  int check_count = 0;

  mips_multicycle_ctrl #(.TIMEOUT(16), .TO_W(5), .CNT_W(32)) dut (
    .Clock(Clock), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .Mem_Ack(Mem_Ack), .Eof(Eof), .Mem_Req(Mem_Req), .Mem_Write(Mem_Write),
    .I_or_D(I_or_D), .IR_Write(IR_Write), .MDR_Write(MDR_Write), .PC_Write(PC_Write),
    .PC_Src(PC_Src), .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B), .ALU_Op(ALU_Op),
    .Reg_Write(Reg_Write), .Reg_Dst(Reg_Dst), .Mem_to_Reg(Mem_to_Reg), .State(State),
    .Instr_Count(Instr_Count), .Halted(Halted), .Fault(Fault)
  );

  // Free-running clock with a 10-time-unit period.
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Opcode = 6'h00; Funct = 6'h20; Zero = 1'b0; Eof = 1'b0; Mem_Ack = 1'b1;
    do_reset();
    check_count++; if (State !== 4'd0) $display("[TB] FAIL reset_state: got %0d expected 0", State); else pass_count++;
    check_count++; if (Mem_Req !== 1'b1) $display("[TB] FAIL reset_mem_req: got %0b expected 1", Mem_Req); else pass_count++;
    check_count++; if (ALU_Src_B !== 2'd1) $display("[TB] FAIL reset_src_b: got %0d expected 1", ALU_Src_B); else pass_count++;
    check_count++; if (Instr_Count !== 32'd0) $display("[TB] FAIL reset_count: got %0d expected 0", Instr_Count); else pass_count++;
    check_count++; if (Fault !== 1'b0 || Halted !== 1'b0) $display("[TB] FAIL reset_flags: got fault=%0b halted=%0b expected 0 0", Fault, Halted); else pass_count++;
    check_count++; if (IR_Write !== 1'b1 || PC_Write !== 1'b1 || PC_Src !== 2'd0) $display("[TB] FAIL fetch_ack: got ir=%0b pc=%0b src=%0d expected 1 1 0", IR_Write, PC_Write, PC_Src); else pass_count++;
  endtask

  task automatic test_rtype();
    step();
    check_count++; if (State !== 4'd1 || ALU_Src_B !== 2'd3 || ALU_Op !== 3'd0) $display("[TB] FAIL add_decode: got st=%0d b=%0d op=%0d expected 1 3 0", State, ALU_Src_B, ALU_Op); else pass_count++;
    step();
    check_count++; if (State !== 4'd2 || ALU_Src_A !== 1'b1 || ALU_Op !== 3'd2 || Reg_Write !== 1'b0) $display("[TB] FAIL add_exec: got st=%0d a=%0b op=%0d rw=%0b expected 2 1 2 0", State, ALU_Src_A, ALU_Op, Reg_Write); else pass_count++;
    step();
    check_count++; if (State !== 4'd7 || Reg_Write !== 1'b1 || Reg_Dst !== 2'd1 || Mem_to_Reg !== 2'd0) $display("[TB] FAIL add_wb: got st=%0d rw=%0b dst=%0d m2r=%0d expected 7 1 1 0", State, Reg_Write, Reg_Dst, Mem_to_Reg); else pass_count++;
    step();
    check_count++; if (State !== 4'd0 || Reg_Write !== 1'b0 || Instr_Count !== 32'd1) $display("[TB] FAIL add_retire: got st=%0d rw=%0b cnt=%0d expected 0 0 1", State, Reg_Write, Instr_Count); else pass_count++;
  endtask

  task automatic test_lw_wait();
    Opcode = 6'h23;
    step();
    Mem_Ack = 1'b0;
    step();
    check_count++; if (State !== 4'd4 || ALU_Src_A !== 1'b1 || ALU_Src_B !== 2'd2) $display("[TB] FAIL lw_addr: got st=%0d a=%0b b=%0d expected 4 1 2", State, ALU_Src_A, ALU_Src_B); else pass_count++;
    step();
    for (int i = 0; i < 2; i++) begin
      check_count++; if (State !== 4'd5 || Mem_Req !== 1'b1 || I_or_D !== 1'b1 || MDR_Write !== 1'b0 || Mem_Write !== 1'b0) $display("[TB] FAIL lw_wait%0d: got st=%0d req=%0b iod=%0b mdr=%0b wr=%0b expected 5 1 1 0 0", i, State, Mem_Req, I_or_D, MDR_Write, Mem_Write); else pass_count++;
      step();
    end
    Mem_Ack = 1'b1;
    #1;
    check_count++; if (State !== 4'd5 || Mem_Req !== 1'b1 || MDR_Write !== 1'b1) $display("[TB] FAIL lw_ack: got st=%0d req=%0b mdr=%0b expected 5 1 1", State, Mem_Req, MDR_Write); else pass_count++;
    step();
    check_count++; if (State !== 4'd9 || Reg_Write !== 1'b1 || Mem_to_Reg !== 2'd1 || Reg_Dst !== 2'd0) $display("[TB] FAIL lw_wb: got st=%0d rw=%0b m2r=%0d dst=%0d expected 9 1 1 0", State, Reg_Write, Mem_to_Reg, Reg_Dst); else pass_count++;
    step();
    check_count++; if (State !== 4'd0 || Instr_Count !== 32'd2) $display("[TB] FAIL lw_retire: got st=%0d cnt=%0d expected 0 2", State, Instr_Count); else pass_count++;
  endtask

  task automatic test_branch();
    Opcode = 6'h04; Zero = 1'b1;
    step(); step();
    check_count++; if (State !== 4'd10 || PC_Write !== 1'b1 || PC_Src !== 2'd1 || ALU_Op !== 3'd1 || ALU_Src_A !== 1'b1) $display("[TB] FAIL beq_taken: got st=%0d pcw=%0b src=%0d op=%0d a=%0b expected 10 1 1 1 1", State, PC_Write, PC_Src, ALU_Op, ALU_Src_A); else pass_count++;
    step();
    check_count++; if (State !== 4'd0 || Instr_Count !== 32'd3) $display("[TB] FAIL beq_retire: got st=%0d cnt=%0d expected 0 3", State, Instr_Count); else pass_count++;
    Opcode = 6'h05;
    step(); step();
    check_count++; if (State !== 4'd10 || PC_Write !== 1'b0) $display("[TB] FAIL bne_not_taken: got st=%0d pcw=%0b expected 10 0", State, PC_Write); else pass_count++;
    Zero = 1'b0;
    #1;
    check_count++; if (PC_Write !== 1'b1) $display("[TB] FAIL bne_taken: got pcw=%0b expected 1", PC_Write); else pass_count++;
    step();
    check_count++; if (State !== 4'd0 || Instr_Count !== 32'd4) $display("[TB] FAIL bne_retire: got st=%0d cnt=%0d expected 0 4", State, Instr_Count); else pass_count++;
  endtask

  task automatic test_jumps();
    Opcode = 6'h03;
    step(); step();
    check_count++; if (State !== 4'd11 || PC_Write !== 1'b1 || PC_Src !== 2'd2 || Reg_Write !== 1'b1 || Reg_Dst !== 2'd2 || Mem_to_Reg !== 2'd2) $display("[TB] FAIL jal: got st=%0d pcw=%0b src=%0d rw=%0b dst=%0d m2r=%0d expected 11 1 2 1 2 2", State, PC_Write, PC_Src, Reg_Write, Reg_Dst, Mem_to_Reg); else pass_count++;
    step();
    Opcode = 6'h00; Funct = 6'h08;
    step(); step();
    check_count++; if (State !== 4'd12 || PC_Write !== 1'b1 || PC_Src !== 2'd3 || Reg_Write !== 1'b0) $display("[TB] FAIL jr: got st=%0d pcw=%0b src=%0d rw=%0b expected 12 1 3 0", State, PC_Write, PC_Src, Reg_Write); else pass_count++;
    step();
    Opcode = 6'h0D; Funct = 6'h20;
    step(); step();
    check_count++; if (State !== 4'd3 || ALU_Op !== 3'd4 || ALU_Src_B !== 2'd2 || ALU_Src_A !== 1'b1) $display("[TB] FAIL ori_exec: got st=%0d op=%0d b=%0d a=%0b expected 3 4 2 1", State, ALU_Op, ALU_Src_B, ALU_Src_A); else pass_count++;
    step();
    check_count++; if (State !== 4'd8 || Reg_Write !== 1'b1 || Reg_Dst !== 2'd0) $display("[TB] FAIL ori_wb: got st=%0d rw=%0b dst=%0d expected 8 1 0", State, Reg_Write, Reg_Dst); else pass_count++;
    step();
    check_count++; if (State !== 4'd0 || Instr_Count !== 32'd7) $display("[TB] FAIL jumps_retire: got st=%0d cnt=%0d expected 0 7", State, Instr_Count); else pass_count++;
  endtask

  task automatic test_timeout();
    logic stayed;
    Opcode = 6'h00; Funct = 6'h20; Mem_Ack = 1'b0;
    do_reset();
    stayed = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (State !== 4'd0 || Mem_Req !== 1'b1) stayed = 1'b0;
      step();
    end
    check_count++; if (stayed !== 1'b1) $display("[TB] FAIL timeout_wait: got held=%0b expected 1", stayed); else pass_count++;
    check_count++; if (State !== 4'd14 || Fault !== 1'b1 || Mem_Req !== 1'b0) $display("[TB] FAIL timeout_fault: got st=%0d fault=%0b req=%0b expected 14 1 0", State, Fault, Mem_Req); else pass_count++;
    Mem_Ack = 1'b1;
    step(); step();
    check_count++; if (State !== 4'd14 || Fault !== 1'b1 || Instr_Count !== 32'd0) $display("[TB] FAIL fault_sticky: got st=%0d fault=%0b cnt=%0d expected 14 1 0", State, Fault, Instr_Count); else pass_count++;
    Mem_Ack = 1'b0;
    do_reset();
    check_count++; if (State !== 4'd0 || Fault !== 1'b0) $display("[TB] FAIL fault_cleared: got st=%0d fault=%0b expected 0 0", State, Fault); else pass_count++;
    for (int i = 0; i < 15; i++) step();
    Mem_Ack = 1'b1;
    #1;
    check_count++; if (State !== 4'd0 || IR_Write !== 1'b1) $display("[TB] FAIL ack_last_cycle: got st=%0d ir=%0b expected 0 1", State, IR_Write); else pass_count++;
    step();
    check_count++; if (State !== 4'd1 || Fault !== 1'b0) $display("[TB] FAIL ack_wins: got st=%0d fault=%0b expected 1 0", State, Fault); else pass_count++;
  endtask

  task automatic test_illegal_halt();
    Opcode = 6'h3F; Mem_Ack = 1'b1;
    do_reset();
    step(); step();
    check_count++; if (State !== 4'd14 || Fault !== 1'b1 || Instr_Count !== 32'd0) $display("[TB] FAIL illegal_op: got st=%0d fault=%0b cnt=%0d expected 14 1 0", State, Fault, Instr_Count); else pass_count++;
    Eof = 1'b1;
    do_reset();
    check_count++; if (State !== 4'd0 || Mem_Req !== 1'b0 || IR_Write !== 1'b0) $display("[TB] FAIL eof_fetch: got st=%0d req=%0b ir=%0b expected 0 0 0", State, Mem_Req, IR_Write); else pass_count++;
    step();
    Eof = 1'b0;
    step();
    check_count++; if (State !== 4'd13 || Halted !== 1'b1 || Mem_Req !== 1'b0 || Fault !== 1'b0) $display("[TB] FAIL halt: got st=%0d halted=%0b req=%0b fault=%0b expected 13 1 0 0", State, Halted, Mem_Req, Fault); else pass_count++;
  endtask

  task automatic test_back_to_back();
    Opcode = 6'h2B; Mem_Ack = 1'b1; Eof = 1'b0;
    do_reset();
    step(); step();
    Mem_Ack = 1'b0;
    step();
    check_count++; if (State !== 4'd6 || Mem_Req !== 1'b1 || Mem_Write !== 1'b1 || I_or_D !== 1'b1) $display("[TB] FAIL sw_mem: got st=%0d req=%0b wr=%0b iod=%0b expected 6 1 1 1", State, Mem_Req, Mem_Write, I_or_D); else pass_count++;
    step(); step();
    Mem_Ack = 1'b1;
    step();
    check_count++; if (State !== 4'd0 || Mem_Write !== 1'b0 || Instr_Count !== 32'd1) $display("[TB] FAIL sw_retire: got st=%0d wr=%0b cnt=%0d expected 0 0 1", State, Mem_Write, Instr_Count); else pass_count++;
    step(); step();
    Mem_Ack = 1'b0;
    step();
    Reset = 1'b1; Mem_Ack = 1'b1;
    step();
    Reset = 1'b0; Mem_Ack = 1'b0;
    check_count++; if (State !== 4'd0 || Mem_Write !== 1'b0 || I_or_D !== 1'b0 || Instr_Count !== 32'd0) $display("[TB] FAIL reset_mid_sw: got st=%0d wr=%0b iod=%0b cnt=%0d expected 0 0 0 0", State, Mem_Write, I_or_D, Instr_Count); else pass_count++;
  endtask

  // Run every scenario in order, then report.
  initial begin
    Reset = 1'b1; Opcode = 6'h00; Funct = 6'h00; Zero = 1'b0; Mem_Ack = 1'b0; Eof = 1'b0;
    @(negedge Clock);
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_jumps();
    test_timeout();
    test_illegal_halt();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
